morph_opening_sequencer: RTL and testbench
==========================================

Name: morph_opening_sequencer

Overview:
- Sequences morphological opening over one binary-mask frame held in a two-bank 4-bit pixel SRAM.
- Per pass: raster-scans the source bank and builds a zero-padded 3x3 window with line buffers.
- Drives the combinational morphological filter's window and enables, then writes the filter result to the other bank.
- Runs an erosion pass, then a dilation pass (each selectable), between mask generation and centroid detection.

Parameters:
- IMG_W, 160, frame width in pixels
- IMG_H, 120, frame height in pixels
- ADDR_W, 15, pixel address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- cfg_erode  in  1  run erosion pass; sampled on accepted start
- cfg_dilate  in  1  run dilation pass; sampled on accepted start
- busy  out  1  high while passes are in progress
- done  out  1  one-cycle completion pulse
- result_bank  out  1  bank holding the final mask; valid from done until the next start
- rd_en  out  1  SRAM read strobe
- rd_bank  out  1  bank being read
- rd_addr  out  ADDR_W  read address, y*IMG_W+x
- rd_data  in  4  read data, valid 1 cycle after rd_en
- wr_en  out  1  SRAM write strobe
- wr_bank  out  1  bank being written (always !rd_bank)
- wr_addr  out  ADDR_W  write address of the window centre
- wr_data  out  4  equals filt_pixel
- erosion_enable  out  1  to filter
- dilation_enable  out  1  to filter
- win  out  36  packed window: p00 in [35:32] ... p22 in [3:0], row-major
- filt_pixel  in  4  filter result, combinational from win

Behaviour:
- Reset values: all outputs 0; state IDLE; result_bank 0; counters 0.
- States: IDLE -> SCAN -> DRAIN -> (SWITCH -> SCAN -> DRAIN) -> IDLE.
- IDLE + start + (cfg_erode | cfg_dilate) -> SCAN. Pass 1 is erosion if cfg_erode, else dilation. Pass 1 reads bank 0 and writes bank 1.
- IDLE + start with both cfg bits 0 -> no memory access. Pulse done next cycle; result_bank = 0.
- start while busy is ignored.
- SCAN: position (x,y) steps over x=0..IMG_W, y=0..IMG_H, one position per cycle, x fastest. That is (IMG_W+1)(IMG_H+1) cycles.
  - rd_en = 1 only when x<IMG_W and y<IMG_H.
  - Out-of-range positions inject pixel 0 (right and bottom padding).
  - Rows above row 0 and columns left of column 0 read as 0 (top and left padding). Implemented by qualification, with no clear cycles.
  - The window column is shifted one cycle after the read, when rd_data arrives. The window is valid the following cycle.
  - Read-to-write latency is 2 cycles.
- Write rule: position (x,y) with x>=1, y>=1 produces a write for centre (x-1, y-1), 2 cycles after its read slot. Exactly IMG_W*IMG_H writes per pass.
- DRAIN: 2 cycles flush the pipeline; the last write occurs in the last DRAIN cycle.
- SWITCH: 1 cycle. Used only if both passes are configured: swap banks (pass 2 reads 1, writes 0), select dilation, reset counters and window.
- Enables: erosion_enable and dilation_enable are one-hot during SCAN/DRAIN for the active pass, 0 otherwise.
- Completion: busy falls, and done pulses, on the cycle after the final DRAIN. result_bank = wr_bank of the last pass.
- Busy length: busy is high for (IMG_W+1)(IMG_H+1)+2 cycles per pass, plus 1 for SWITCH.
- rst_n low mid-pass: immediate return to IDLE and all strobes 0. Bank contents are undefined, and no done pulse is issued.

Optional Feature:
- MORPH_PIXCOUNT_EN defined:
  - Adds output skin_count [$clog2(IMG_W*IMG_H+1)-1:0].
  - Counts nonzero wr_data on the final pass's writes; cleared on accepted start.
  - Valid from done; reset 0.
- Undefined: port and counter are absent.

Decomposition:
- morph_pkg holds:
  - state enum
  - window packing index constants (P00_MSB..P22_LSB)
  - default IMG_W/IMG_H
  - function addr_of(x,y)
- Sub-module morph_window_gen holds:
  - two IMG_W x 4 line buffers
  - the 3x3 register window
  - padding qualification
  - inputs: shift, pixel, row_start, top_valid

Test Plan:
- IMG_W=8, IMG_H=6, bank0 single 4'hF at (3,3), erode+dilate -> bank0 all 0, result_bank=0, busy high 131 cycles, 96 writes total.
- Bank0 4'hF block x,y in 2..4, erode+dilate -> after pass 1, bank1 has only (3,3)=F; final bank0 has exactly the 3x3 block F.
- Bank0 all 4'hF, erode only -> bank1 border pixels 0, interior (1..6, 1..4) F, result_bank=1, busy 65 cycles.
- start with cfg_erode=cfg_dilate=0 -> done the next cycle, no rd_en/wr_en, result_bank=0.
- rst_n low 5 cycles into pass 2, then start erode+dilate on the known 3x3 block -> outputs 0 during reset; rerun gives the same result as scenario 2.
- start pulsed during SCAN -> ignored, single done. With MORPH_PIXCOUNT_EN on scenario 2: skin_count=9.

Source files
------------

// File: rtl/morph_pkg.sv
// ============================================================================
// Module      : morph_pkg
// Description : Shared constants, state encoding and address helper for the
//               morphological opening sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package morph_pkg;

   localparam int DEF_IMG_W = 160;
   localparam int DEF_IMG_H = 120;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SCAN   = 2'd1;
   localparam logic [1:0] ST_DRAIN  = 2'd2;
   localparam logic [1:0] ST_SWITCH = 2'd3;

   // Packed window layout: row-major, p00 (top-left) in the top nibble
   localparam int P00_MSB = 35;
   localparam int P00_LSB = 32;
   localparam int P01_MSB = 31;
   localparam int P01_LSB = 28;
   localparam int P02_MSB = 27;
   localparam int P02_LSB = 24;
   localparam int P10_MSB = 23;
   localparam int P10_LSB = 20;
   localparam int P11_MSB = 19;
   localparam int P11_LSB = 16;
   localparam int P12_MSB = 15;
   localparam int P12_LSB = 12;
   localparam int P20_MSB = 11;
   localparam int P20_LSB = 8;
   localparam int P21_MSB = 7;
   localparam int P21_LSB = 4;
   localparam int P22_MSB = 3;
   localparam int P22_LSB = 0;

   function automatic int addr_of(input int x, input int y, input int w);
      return y * w + x;
   endfunction

endpackage

`default_nettype wire

// File: rtl/morph_window_gen.sv
// ============================================================================
// Module      : morph_window_gen
// Description : Two line buffers and a 3x3 register window with zero padding
//               applied by qualification of the incoming column.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morph_window_gen
   import morph_pkg::*;
#(
   parameter int IMG_W = DEF_IMG_W
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        shift,
   input  logic [3:0]  pixel,
   input  logic        row_start,
   input  logic [1:0]  top_valid,
   output logic [35:0] win
);

   localparam int CW = $clog2(IMG_W + 1);
   localparam int IW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam logic [CW-1:0] C_COLS = CW'(IMG_W);

   logic [3:0]    r_lb_top [IMG_W];
   logic [3:0]    r_lb_mid [IMG_W];
   logic [3:0]    r_p [3][3];
   logic [CW-1:0] r_col;

   logic [CW-1:0] w_col;
   logic          w_in;
   logic [IW-1:0] w_idx;
   logic [3:0]    w_top;
   logic [3:0]    w_mid;

   assign w_col = row_start ? '0 : r_col;
   assign w_in  = (w_col < C_COLS);
   assign w_idx = w_col[IW-1:0];
   // top_valid[1]: row y-2 exists, top_valid[0]: row y-1 exists
   assign w_top = (w_in && top_valid[1]) ? r_lb_top[w_idx] : 4'd0;
   assign w_mid = (w_in && top_valid[0]) ? r_lb_mid[w_idx] : 4'd0;

   always_ff @(posedge clk) begin
      if (shift && w_in) begin
         r_lb_top[w_idx] <= r_lb_mid[w_idx];
         r_lb_mid[w_idx] <= pixel;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_col <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               r_p[r][c] <= 4'd0;
      end else if (clr) begin
         r_col <= '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               r_p[r][c] <= 4'd0;
      end else if (shift) begin
         r_col <= w_col + CW'(1);
         // A new row starts with the two older columns forced to the left pad
         for (int r = 0; r < 3; r++) begin
            r_p[r][0] <= row_start ? 4'd0 : r_p[r][1];
            r_p[r][1] <= row_start ? 4'd0 : r_p[r][2];
         end
         r_p[0][2] <= w_top;
         r_p[1][2] <= w_mid;
         r_p[2][2] <= pixel;
      end
   end

   assign win[P00_MSB:P00_LSB] = r_p[0][0];
   assign win[P01_MSB:P01_LSB] = r_p[0][1];
   assign win[P02_MSB:P02_LSB] = r_p[0][2];
   assign win[P10_MSB:P10_LSB] = r_p[1][0];
   assign win[P11_MSB:P11_LSB] = r_p[1][1];
   assign win[P12_MSB:P12_LSB] = r_p[1][2];
   assign win[P20_MSB:P20_LSB] = r_p[2][0];
   assign win[P21_MSB:P21_LSB] = r_p[2][1];
   assign win[P22_MSB:P22_LSB] = r_p[2][2];

endmodule

`default_nettype wire

// File: rtl/morph_opening_sequencer.sv
// ============================================================================
// Module      : morph_opening_sequencer
// Description : Erosion/dilation pass sequencer over a two-bank pixel SRAM.
//               Optional MORPH_PIXCOUNT_EN adds the skin_count output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module morph_opening_sequencer
   import morph_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int ADDR_W = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              cfg_erode,
   input  logic              cfg_dilate,
   output logic              busy,
   output logic              done,
   output logic              result_bank,
   output logic              rd_en,
   output logic              rd_bank,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [3:0]        rd_data,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [3:0]        wr_data,
   output logic              erosion_enable,
   output logic              dilation_enable,
   output logic [35:0]       win,
   input  logic [3:0]        filt_pixel
`ifdef MORPH_PIXCOUNT_EN
  ,output logic [$clog2(IMG_W*IMG_H+1)-1:0] skin_count
`endif
);

   localparam int XW = $clog2(IMG_W + 1);
   localparam int YW = $clog2(IMG_H + 1);
   localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W);
   localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_H);

   logic [1:0]        r_state;
   logic [XW-1:0]     r_x;
   logic [YW-1:0]     r_y;
   logic              r_drain;
   logic              r_bank;
   logic              r_dilate;
   logic              r_two_pass;
   logic              r_done;
   logic              r_result_bank;
   logic              r_s1_valid;
   logic              r_s1_rd;
   logic [XW-1:0]     r_s1_x;
   logic [YW-1:0]     r_s1_y;
   logic              r_s2_wr;
   logic [ADDR_W-1:0] r_s2_addr;

   logic              w_active;
   logic              w_rd;
   logic              w_idle;
   logic [3:0]        w_pixel;
   logic [1:0]        w_top_valid;

   assign w_idle   = (r_state == ST_IDLE);
   assign w_active = (r_state == ST_SCAN) || (r_state == ST_DRAIN);
   assign w_rd     = (r_state == ST_SCAN) && (r_x < C_X_LAST) && (r_y < C_Y_LAST);

   assign busy            = !w_idle;
   assign done            = r_done;
   assign result_bank     = r_result_bank;
   assign rd_en           = w_rd;
   assign rd_bank         = w_idle ? 1'b0 : r_bank;
   assign rd_addr         = w_rd ? ADDR_W'(addr_of(int'(r_x), int'(r_y), IMG_W)) : '0;
   assign wr_en           = r_s2_wr;
   assign wr_bank         = w_idle ? 1'b0 : !r_bank;
   assign wr_addr         = r_s2_wr ? r_s2_addr : '0;
   assign wr_data         = filt_pixel;
   assign erosion_enable  = w_active && !r_dilate;
   assign dilation_enable = w_active && r_dilate;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_x           <= '0;
         r_y           <= '0;
         r_drain       <= 1'b0;
         r_bank        <= 1'b0;
         r_dilate      <= 1'b0;
         r_two_pass    <= 1'b0;
         r_done        <= 1'b0;
         r_result_bank <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  if (cfg_erode || cfg_dilate) begin
                     r_state    <= ST_SCAN;
                     r_x        <= '0;
                     r_y        <= '0;
                     r_bank     <= 1'b0;
                     r_dilate   <= !cfg_erode;
                     r_two_pass <= cfg_erode && cfg_dilate;
                  end else begin
                     r_done        <= 1'b1;
                     r_result_bank <= 1'b0;
                  end
               end
            end
            ST_SCAN: begin
               if (r_x == C_X_LAST) begin
                  r_x <= '0;
                  if (r_y == C_Y_LAST) begin
                     r_state <= ST_DRAIN;
                     r_drain <= 1'b0;
                  end else begin
                     r_y <= r_y + YW'(1);
                  end
               end else begin
                  r_x <= r_x + XW'(1);
               end
            end
            ST_DRAIN: begin
               if (r_drain) begin
                  if (r_two_pass) begin
                     r_state <= ST_SWITCH;
                  end else begin
                     r_state       <= ST_IDLE;
                     r_done        <= 1'b1;
                     r_result_bank <= !r_bank;
                  end
               end else begin
                  r_drain <= 1'b1;
               end
            end
            default: begin
               r_state    <= ST_SCAN;
               r_bank     <= 1'b1;
               r_dilate   <= 1'b1;
               r_two_pass <= 1'b0;
               r_x        <= '0;
               r_y        <= '0;
            end
         endcase
      end
   end

   // Stage 1 tracks the read slot; stage 2 marks the cycle the window is valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_rd    <= 1'b0;
         r_s1_x     <= '0;
         r_s1_y     <= '0;
         r_s2_wr    <= 1'b0;
         r_s2_addr  <= '0;
      end else begin
         r_s1_valid <= (r_state == ST_SCAN);
         r_s1_rd    <= w_rd;
         r_s1_x     <= r_x;
         r_s1_y     <= r_y;
         r_s2_wr    <= r_s1_valid && (r_s1_x != '0) && (r_s1_y != '0);
         r_s2_addr  <= ADDR_W'(addr_of(int'(r_s1_x) - 1, int'(r_s1_y) - 1, IMG_W));
      end
   end

   assign w_pixel     = r_s1_rd ? rd_data : 4'd0;
   assign w_top_valid = {(r_s1_y > YW'(1)), (r_s1_y != '0)};

   morph_window_gen #(
      .IMG_W(IMG_W)
   ) u_window_gen (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (r_state == ST_SWITCH),
      .shift     (r_s1_valid),
      .pixel     (w_pixel),
      .row_start (r_s1_x == '0),
      .top_valid (w_top_valid),
      .win       (win)
   );

`ifdef MORPH_PIXCOUNT_EN
   localparam int SCW = $clog2(IMG_W * IMG_H + 1);
   logic           r_final_pass;
   logic [SCW-1:0] r_skin_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_final_pass <= 1'b0;
         r_skin_count <= '0;
      end else if (w_idle && start) begin
         r_final_pass <= !(cfg_erode && cfg_dilate);
         r_skin_count <= '0;
      end else begin
         if (r_state == ST_SWITCH)
            r_final_pass <= 1'b1;
         if (r_s2_wr && r_final_pass && (wr_data != 4'd0))
            r_skin_count <= r_skin_count + SCW'(1);
      end
   end

   assign skin_count = r_skin_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_morph_opening_sequencer.sv
// ============================================================================
// Module      : tb_morph_opening_sequencer
// Description : Randomized and directed self-checking bench with an SRAM model,
//               a min/max filter model and a frame-level opening reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morph_opening_sequencer;

   localparam int W    = 8;
   localparam int H    = 6;
   localparam int AW   = 6;
   localparam int NPIX = W * H;
   localparam int P    = (W + 1) * (H + 1) + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          cfg_erode = 1'b0;
   logic          cfg_dilate = 1'b0;
   logic          busy, done, result_bank, rd_en, rd_bank, wr_en, wr_bank;
   logic [AW-1:0] rd_addr, wr_addr;
   logic [3:0]    rd_data = 4'd0;
   logic [3:0]    wr_data, filt_pixel;
   logic          erosion_enable, dilation_enable;
   logic [35:0]   win;
`ifdef MORPH_PIXCOUNT_EN
   logic [$clog2(NPIX+1)-1:0] skin_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [3:0] mem  [2][64];
   logic [3:0] img0 [NPIX];
   logic [3:0] exp0 [NPIX];
   logic [3:0] exp1 [NPIX];

   morph_opening_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cfg_erode(cfg_erode),
      .cfg_dilate(cfg_dilate), .busy(busy), .done(done), .result_bank(result_bank),
      .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
      .erosion_enable(erosion_enable), .dilation_enable(dilation_enable),
      .win(win), .filt_pixel(filt_pixel)
`ifdef MORPH_PIXCOUNT_EN
     ,.skin_count(skin_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (rd_en) rd_data <= mem[rd_bank][rd_addr];

   // Filter model: erosion is the window minimum, dilation the maximum
   logic [3:0] f_lo, f_hi, f_v;
   always_comb begin
      f_lo = 4'hF;
      f_hi = 4'h0;
      f_v  = 4'h0;
      for (int i = 0; i < 9; i++) begin
         f_v = win[i*4 +: 4];
         if (f_v < f_lo) f_lo = f_v;
         if (f_v > f_hi) f_hi = f_v;
      end
      filt_pixel = erosion_enable ? f_lo : (dilation_enable ? f_hi : 4'h0);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] outvec();
      return {3'b0, busy, done, rd_en, wr_en, erosion_enable, dilation_enable,
              result_bank, rd_bank, wr_bank, rd_addr, wr_addr, wr_data, win};
   endfunction

   function automatic logic [3:0] nbh(input bit src1, input bit dil, input int x, input int y);
      logic [3:0] r, v;
      r = dil ? 4'h0 : 4'hF;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++) begin
            if (x + dx < 0 || x + dx >= W || y + dy < 0 || y + dy >= H) v = 4'h0;
            else v = src1 ? exp1[(y+dy)*W + x + dx] : img0[(y+dy)*W + x + dx];
            if (dil) r = (v > r) ? v : r;
            else     r = (v < r) ? v : r;
         end
      return r;
   endfunction

   task automatic predict(input bit e, input bit d);
      for (int i = 0; i < NPIX; i++) begin
         exp0[i] = img0[i];
         exp1[i] = mem[1][i];
      end
      if (e || d)
         for (int i = 0; i < NPIX; i++) exp1[i] = nbh(1'b0, !e, i % W, i / W);
      if (e && d)
         for (int i = 0; i < NPIX; i++) exp0[i] = nbh(1'b1, 1'b1, i % W, i / W);
   endtask

   task automatic load_frame();
      for (int i = 0; i < 64; i++) begin
         mem[0][i] = (i < NPIX) ? img0[i] : 4'h0;
         mem[1][i] = 4'($urandom);
      end
   endtask

   task automatic set_block(input int x0, input int x1, input int y0, input int y1);
      for (int i = 0; i < NPIX; i++)
         img0[i] = ((i % W) >= x0 && (i % W) <= x1 && (i / W) >= y0 && (i / W) <= y1) ? 4'hF : 4'h0;
   endtask

   task automatic run_op(input bit e, input bit d, input int inj, input int rst_at);
      int  k, nwr, nrd, nd, bad_bank, bad_en, passes, exp_busy, cnt;
      bit  seen, p2, sw, exp_dil;
      k = 0; nwr = 0; nrd = 0; nd = 0; bad_bank = 0; bad_en = 0; seen = 1'b0;
      passes   = int'(e) + int'(d);
      exp_busy = (passes == 2) ? 2 * P + 1 : ((passes == 1) ? P : 0);
      load_frame();
      predict(e, d);
      @(negedge clk);
      start = 1'b1; cfg_erode = e; cfg_dilate = d;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         if (c > 0) @(negedge clk);
         start = (c == inj);
         if (rst_at >= 0 && k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("reset_mid_pass", outvec(), 64'd0);
            repeat (3) @(negedge clk);
            chk("reset_held", outvec(), 64'd0);
            rst_n = 1'b1;
            return;
         end
         if (busy) begin
            p2 = (k > P);
            sw = (k == P);
            exp_dil = p2 ? 1'b1 : !e;
            if ({erosion_enable, dilation_enable} !== (sw ? 2'b00 : {!exp_dil, exp_dil})) bad_en++;
            if (rd_en && rd_bank !== p2) bad_bank++;
            if (wr_en && wr_bank !== !p2) bad_bank++;
            k++;
         end
         if (rd_en) nrd++;
         if (wr_en) begin
            nwr++;
            mem[wr_bank][wr_addr] = wr_data;
         end
         if (done) begin
            nd++;
            seen = 1'b1;
         end
      end
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("busy_cycles", 64'(k), 64'(exp_busy));
      chk("done_pulses", 64'(nd), 64'd1);
      chk("busy_after_done", 64'(busy), 64'd0);
      chk("write_count", 64'(nwr), 64'(passes * NPIX));
      chk("read_count", 64'(nrd), 64'(passes * NPIX));
      chk("result_bank", 64'(result_bank), (passes == 1) ? 64'd1 : 64'd0);
      chk("bank_select_errors", 64'(bad_bank), 64'd0);
      chk("enable_errors", 64'(bad_en), 64'd0);
      for (int i = 0; i < NPIX; i++) begin
         chk($sformatf("bank0[%0d,%0d]", i % W, i / W), 64'(mem[0][i]), 64'(exp0[i]));
         chk($sformatf("bank1[%0d,%0d]", i % W, i / W), 64'(mem[1][i]), 64'(exp1[i]));
      end
      cnt = 0;
      for (int i = 0; i < NPIX; i++)
         if (passes == 2 && exp0[i] != 4'h0) cnt++;
         else if (passes == 1 && exp1[i] != 4'h0) cnt++;
`ifdef MORPH_PIXCOUNT_EN
      chk("skin_count", 64'(skin_count), 64'(cnt));
`endif
   endtask

   initial begin
      for (int i = 0; i < NPIX; i++) img0[i] = 4'h0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", outvec(), 64'd0);
      rst_n = 1'b1;

      // Isolated pixel vanishes under opening
      set_block(3, 3, 3, 3);
      run_op(1'b1, 1'b1, -1, -1);

      // 3x3 block survives opening; a stray start during SCAN is ignored
      set_block(2, 4, 2, 4);
      run_op(1'b1, 1'b1, 10, -1);

      // Full frame eroded: border cleared by zero padding
      set_block(0, W - 1, 0, H - 1);
      run_op(1'b1, 1'b0, -1, -1);

      // No pass configured: immediate done, no memory traffic
      run_op(1'b0, 1'b0, -1, -1);

      // Reset during pass 2, then a clean rerun of the block case
      set_block(2, 4, 2, 4);
      run_op(1'b1, 1'b1, -1, P + 1 + 5);
      run_op(1'b1, 1'b1, -1, -1);

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < NPIX; i++)
            img0[i] = ($urandom_range(0, 2) == 0) ? 4'h0 : (($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
         run_op(1'($urandom), 1'($urandom), ($urandom_range(0, 1) == 1) ? int'($urandom_range(5, 60)) : -1, -1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
